// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: ALU control encodings and request/response record types
package alu_share_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int MAX_ID_W = 3;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [3:0]      ctrl;
    logic            diff;
  } alu_req_t;
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [XLEN-1:0]     data;
    logic                zero;
  } alu_rsp_t;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU and response bundle of the shared-ALU arbiter
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_diff;
  logic [NUM_REQ*DATA_W-1:0] req_in1;
  logic [NUM_REQ*DATA_W-1:0] req_in2;
  logic [NUM_REQ*4-1:0]      req_ctrl;
  logic [DATA_W-1:0]         alu_in1;
  logic [DATA_W-1:0]         alu_in2;
  logic [3:0]                alu_contrl;
  logic                      alu_diff;
  logic [DATA_W-1:0]         alu_out;
  logic                      alu_zero;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_zero;
  modport slave (
    input  req_valid, req_in1, req_in2, req_ctrl, req_diff, alu_out, alu_zero, rsp_ready,
    output req_ready, alu_in1, alu_in2, alu_contrl, alu_diff, rsp_valid, rsp_id, rsp_data, rsp_zero
  );
  modport master (
    output req_valid, req_in1, req_in2, req_ctrl, req_diff, alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_in1, alu_in2, alu_contrl, alu_diff, rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick scanning upward from an owned pointer that advances past each grant
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);
  localparam logic [W:0] NN = (W+1)'(N);
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W:0]   sum;
  logic [W-1:0] idx;
  logic         found;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr_q} + (W+1)'(k);
      idx = sum >= NN ? W'(sum - NN) : W'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
    rr_ptr_d = advance ? (gnt_idx == W'(N-1) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: grants one requester per cycle to the shared ALU and registers its result
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  alu_share_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               slot_free, accept;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_zero_q, rsp_zero_d;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .req(bus.req_valid),
    .advance(accept),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  // draining and refilling the slot in the same cycle keeps one op per cycle
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    bus.req_ready = (rst_n && slot_free) ? gnt : '0;
    accept = |(bus.req_valid & bus.req_ready);
    bus.alu_in1 = '0;
    bus.alu_in2 = '0;
    bus.alu_contrl = ALU_ADD;
    bus.alu_diff = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bus.alu_in1 = bus.req_in1[i*DATA_W +: DATA_W];
        bus.alu_in2 = bus.req_in2[i*DATA_W +: DATA_W];
        bus.alu_contrl = bus.req_ctrl[i*4 +: 4];
        bus.alu_diff = bus.req_diff[i];
      end
    end
    rsp_valid_d = accept || (rsp_valid_q && !bus.rsp_ready);
    rsp_id_d = accept ? gnt_idx : rsp_id_q;
    rsp_data_d = accept ? bus.alu_out : rsp_data_q;
    rsp_zero_d = accept ? bus.alu_zero : rsp_zero_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_zero = rsp_zero_q;
endmodule
